// File: rtl/axi_tensor_mem_slave.sv
// AXI responder memory for the tensor core: AR/R read bursts and AW/W write
// bursts served from one word-organised RAM, plus a combinational backdoor
// port. There is no B channel because the initiator does not have one.
//
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high, waiting for an AR handshake
//   R_DATA  | rvalid high, presenting the current beat until rready
//
// Write FSM
//   state   | meaning
//   W_IDLE  | awready high, waiting for an AW handshake
//   W_DATA  | wready high, accepting beats until awlen+1 have been taken
//   W_DRAIN | one idle cycle after the final beat before returning to W_IDLE
module axi_tensor_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [1:0]               s_axi_arburst,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [DATA_WIDTH-1:0]    s_axi_rdata,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic [7:0]               s_axi_awlen,
    input  logic [2:0]               s_axi_awsize,
    input  logic [1:0]               s_axi_awburst,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [DATA_WIDTH-1:0]    s_axi_wdata,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic                     s_axi_wlast,
    output logic                     proto_err,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    input  logic                     dbg_we,
    input  logic [DATA_WIDTH-1:0]    dbg_wdata,
    output logic [DATA_WIDTH-1:0]    dbg_rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    // Beats wider than the RAM word are treated as full-word beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > MAX_SIZE) ? MAX_SIZE : s;
    endfunction

    // FIXED bursts stay on one address; INCR and the reserved codes step.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0]            sz,
                                                        input logic                  fixed);
        if (fixed) return a;
        return a + (ADDR_WIDTH'(1) << sz);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------------------------------------------------------- read
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    rstate_t                 rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic [7:0]              rlen_q, rlen_d;
    logic [7:0]              rbeat_q, rbeat_d;
    logic [2:0]              rsize_q, rsize_d;
    logic                    rfixed_q, rfixed_d;
    logic                    rlast_q, rlast_d;
    logic                    arready_q, arready_d;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rd_fetch;
    logic [IDX_W-1:0]        rd_fetch_idx;
    logic                    rd_err;

    // Read state register and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rsize_q   <= '0;
            rfixed_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rsize_q   <= rsize_d;
            rfixed_q  <= rfixed_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
        end
    end

    // Read next-state: latch AR, then fetch one word per accepted beat.
    always_comb begin
        rstate_d     = rstate_q;
        raddr_d      = raddr_q;
        rlen_d       = rlen_q;
        rbeat_d      = rbeat_q;
        rsize_d      = rsize_q;
        rfixed_d     = rfixed_q;
        rlast_d      = rlast_q;
        rd_fetch     = 1'b0;
        rd_fetch_idx = raddr_q[OFF_W +: IDX_W];
        rd_err       = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    raddr_d      = s_axi_araddr;
                    rlen_d       = s_axi_arlen;
                    rsize_d      = clamp_size(s_axi_arsize);
                    rfixed_d     = (s_axi_arburst == 2'b00);
                    rbeat_d      = '0;
                    rlast_d      = (s_axi_arlen == 8'd0);
                    rd_fetch     = 1'b1;
                    rd_fetch_idx = s_axi_araddr[OFF_W +: IDX_W];
                    rd_err       = (s_axi_arsize > MAX_SIZE);
                    rstate_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rbeat_q == rlen_q) begin
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        raddr_d      = step_addr(raddr_q, rsize_q, rfixed_q);
                        rbeat_d      = rbeat_q + 8'd1;
                        rlast_d      = ((rbeat_q + 8'd1) == rlen_q);
                        rd_fetch     = 1'b1;
                        rd_fetch_idx = raddr_d[OFF_W +: IDX_W];
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    // Read data register; sampling the array at the edge gives old data on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_fetch) begin
            rdata_q <= mem[rd_fetch_idx];
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;

    // --------------------------------------------------------------- write
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DRAIN} wstate_t;

    wstate_t                 wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [7:0]              wlen_q, wlen_d;
    logic [7:0]              wbeat_q, wbeat_d;
    logic [2:0]              wsize_q, wsize_d;
    logic                    wfixed_q, wfixed_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    wr_en;
    logic                    wr_err;

    // Write state register and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wsize_q   <= '0;
            wfixed_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wsize_q   <= wsize_d;
            wfixed_q  <= wfixed_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    // Write next-state: the burst length comes from our own count, wlast is only checked.
    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wbeat_d  = wbeat_q;
        wsize_d  = wsize_q;
        wfixed_d = wfixed_q;
        wr_en    = 1'b0;
        wr_err   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    waddr_d  = s_axi_awaddr;
                    wlen_d   = s_axi_awlen;
                    wsize_d  = clamp_size(s_axi_awsize);
                    wfixed_d = (s_axi_awburst == 2'b00);
                    wbeat_d  = '0;
                    wr_err   = (s_axi_awsize > MAX_SIZE);
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    wr_en = 1'b1;
                    if (wbeat_q == wlen_q) begin
                        wr_err   = !s_axi_wlast;
                        wstate_d = W_DRAIN;
                    end else begin
                        wr_err  = s_axi_wlast;
                        wbeat_d = wbeat_q + 8'd1;
                        waddr_d = step_addr(waddr_q, wsize_q, wfixed_q);
                    end
                end
            end
            W_DRAIN: wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
    end

    logic [IDX_W-1:0]      wr_idx;
    logic [OFF_W-1:0]      wr_off;
    logic                  wr_full;
    logic [DATA_WIDTH-1:0] wr_shift;
    logic [DATA_WIDTH-1:0] wr_mask;

    assign wr_idx  = waddr_q[OFF_W +: IDX_W];
    assign wr_off  = waddr_q[OFF_W-1:0];
    assign wr_full = (wsize_q == MAX_SIZE);

    // Byte-lane placement: narrow beats land at the address offset inside the word.
    always_comb begin
        wr_mask  = '0;
        wr_shift = s_axi_wdata << {wr_off, 3'b000};
        if (wr_full) wr_shift = s_axi_wdata;
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_full || (b >= int'(wr_off) && b < int'(wr_off) + (1 << wsize_q))) begin
                wr_mask[b*8 +: 8] = 8'hFF;
            end
        end
    end

    // RAM write port; the backdoor write is last so it wins on the same word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_shift & wr_mask);
        if (dbg_we) mem[dbg_addr] <= dbg_wdata;
    end

    assign dbg_rdata     = mem[dbg_addr];
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;

    // Sticky protocol error flag, cleared only by reset.
    logic proto_err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (rd_err || wr_err) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_tensor_mem_slave.sv
// Directed bench for axi_tensor_mem_slave: bursts, stalls, narrow writes,
// FIXED/wrap addressing, wlast errors, oversize beats and mid-burst reset.
module tb_axi_tensor_mem_slave;

    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int DEPTH = 4096;
    localparam int IW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_axi_araddr = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic [2:0]    s_axi_arsize = '0;
    logic [1:0]    s_axi_arburst = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [2:0]    s_axi_awsize = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic          s_axi_wlast = 1'b0;
    logic          proto_err;
    logic [IW-1:0] dbg_addr = '0;
    logic          dbg_we = 1'b0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [DW-1:0] dbg_rdata;

    always #5 clk = ~clk;

    axi_tensor_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wlast(s_axi_wlast), .proto_err(proto_err),
        .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] rd_data[$];
    logic          rd_last[$];
    int            rd_hold_err;
    int            rd_first_lat;
    logic          post_rvalid, post_arready;
    int            wr_beats;
    logic          post_wready;

    // Preload pattern: word i holds i*0x1111.
    function automatic logic [DW-1:0] pre_word(input int i);
        logic [DW-1:0] v;
        v = '0;
        v[31:0] = 32'(i) * 32'h1111;
        return v;
    endfunction

    // Narrow-write pattern: word w lane j holds 8w+j.
    function automatic logic [DW-1:0] t3_word(input int w);
        logic [DW-1:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = 32'(8*w + j);
        return v;
    endfunction

    function automatic logic [DW-1:0] beat_word(input int b);
        logic [DW-1:0] v;
        v = '0;
        v[31:0] = 32'(b);
        return v;
    endfunction

    task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int n;
        bit held;
        logic [DW-1:0] hd;
        logic hl;
        rd_data.delete();
        rd_last.delete();
        rd_hold_err  = 0;
        rd_first_lat = -1;
        held = 0;
        hd = '0;
        hl = 1'b0;
        @(posedge clk); #1;
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        while (rd_data.size() < int'(len) + 1 && n < 2000) begin
            s_axi_rready = stall ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            if (s_axi_rvalid === 1'b1 && rd_first_lat < 0) rd_first_lat = n;
            if (held && (s_axi_rdata !== hd || s_axi_rlast !== hl || s_axi_rvalid !== 1'b1))
                rd_hold_err++;
            held = (s_axi_rvalid === 1'b1) && !s_axi_rready;
            hd = s_axi_rdata;
            hl = s_axi_rlast;
            if (s_axi_rvalid === 1'b1 && s_axi_rready) begin
                rd_data.push_back(s_axi_rdata);
                rd_last.push_back(s_axi_rlast);
            end
            @(posedge clk); #1;
            n++;
        end
        s_axi_rready = 1'b0;
        post_rvalid  = s_axi_rvalid;
        post_arready = s_axi_arready;
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int wlast_beat);
        int n;
        wr_beats = 0;
        @(posedge clk); #1;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b1;
        n = 0;
        while (wr_beats < int'(len) + 1 && n < 2000) begin
            s_axi_wdata = beat_word(wr_beats);
            s_axi_wlast = (wr_beats == wlast_beat);
            if (s_axi_wready === 1'b1) wr_beats++;
            @(posedge clk); #1;
            n++;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        post_wready  = s_axi_wready;
    endtask

    task automatic test_reset();
        tests_run++;
        if (s_axi_arready !== 1'b0 || s_axi_awready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: arready=%b awready=%b expected 0 0", s_axi_arready, s_axi_awready);
        end
        tests_run++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_wready !== 1'b0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: rvalid=%b rlast=%b wready=%b proto_err=%b expected all 0",
                     s_axi_rvalid, s_axi_rlast, s_axi_wready, proto_err);
        end
        tests_run++;
        if (s_axi_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 0", s_axi_rdata);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (s_axi_arready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: arready=%b expected 0", s_axi_arready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_edge: arready=%b awready=%b expected 1 1", s_axi_arready, s_axi_awready);
        end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            dbg_we = 1'b1; dbg_addr = IW'(i); dbg_wdata = pre_word(i);
        end
        @(posedge clk); #1;
        dbg_we = 1'b0;
        dbg_addr = IW'(3);
        #1;
        tests_run++;
        if (dbg_rdata !== pre_word(3)) begin
            tests_failed++;
            $display("FAIL dbg_readback: got %h expected %h", dbg_rdata, pre_word(3));
        end
    endtask

    task automatic test_read_incr();
        read_burst(32'h0, 8'd7, 3'd5, 2'b01, 1'b0);
        tests_run++;
        if (rd_data.size() != 8 || rd_first_lat != 0) begin
            tests_failed++;
            $display("FAIL incr_count: beats=%0d first_lat=%0d expected 8 0", rd_data.size(), rd_first_lat);
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            tests_run++;
            if (rd_data[i] !== pre_word(i) || rd_last[i] !== (i == 7)) begin
                tests_failed++;
                $display("FAIL incr_beat%0d: data=%h last=%b expected %h %b", i, rd_data[i], rd_last[i],
                         pre_word(i), (i == 7));
            end
        end
        tests_run++;
        if (post_rvalid !== 1'b0 || post_arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL incr_end: rvalid=%b arready=%b expected 0 1", post_rvalid, post_arready);
        end
    endtask

    task automatic test_read_stall();
        read_burst(32'h0, 8'd7, 3'd5, 2'b01, 1'b1);
        tests_run++;
        if (rd_data.size() != 8 || rd_hold_err != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: beats=%0d hold_errors=%0d expected 8 0", rd_data.size(), rd_hold_err);
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            tests_run++;
            if (rd_data[i] !== pre_word(i) || rd_last[i] !== (i == 7)) begin
                tests_failed++;
                $display("FAIL stall_beat%0d: data=%h last=%b expected %h %b", i, rd_data[i], rd_last[i],
                         pre_word(i), (i == 7));
            end
        end
    endtask

    task automatic test_write_narrow();
        write_burst(32'h0, 8'd255, 3'd2, 2'b01, 255);
        tests_run++;
        if (wr_beats != 256 || post_wready !== 1'b0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL narrow_burst: beats=%0d wready=%b proto_err=%b expected 256 0 0",
                     wr_beats, post_wready, proto_err);
        end
        for (int w = 0; w < 32; w++) begin
            dbg_addr = IW'(w);
            #1;
            tests_run++;
            if (dbg_rdata !== t3_word(w)) begin
                tests_failed++;
                $display("FAIL narrow_word%0d: got %h expected %h", w, dbg_rdata, t3_word(w));
            end
        end
    endtask

    task automatic test_read_fixed_wrap();
        read_burst(32'h20, 8'd3, 3'd5, 2'b00, 1'b0);
        tests_run++;
        if (rd_data.size() != 4) begin
            tests_failed++;
            $display("FAIL fixed_count: beats=%0d expected 4", rd_data.size());
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            tests_run++;
            if (rd_data[i] !== t3_word(1) || rd_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL fixed_beat%0d: data=%h last=%b expected %h %b", i, rd_data[i], rd_last[i],
                         t3_word(1), (i == 3));
            end
        end
        read_burst(AW'(DEPTH*32 + 32'h40), 8'd0, 3'd5, 2'b01, 1'b0);
        tests_run++;
        if (rd_data.size() != 1 || rd_data[0] !== t3_word(2) || rd_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_read: beats=%0d data=%h expected 1 %h", rd_data.size(),
                     (rd_data.size() > 0) ? rd_data[0] : '0, t3_word(2));
        end
    endtask

    task automatic test_write_readback();
        write_burst(32'd300 * 32, 8'd1, 3'd5, 2'b01, 1);
        read_burst(32'd300 * 32, 8'd1, 3'd5, 2'b01, 1'b0);
        tests_run++;
        if (rd_data.size() != 2 || rd_data[0] !== beat_word(0) || rd_data[1] !== beat_word(1)) begin
            tests_failed++;
            $display("FAIL write_readback: beats=%0d d0=%h d1=%h expected 2 %h %h", rd_data.size(),
                     (rd_data.size() > 0) ? rd_data[0] : '0, (rd_data.size() > 1) ? rd_data[1] : '0,
                     beat_word(0), beat_word(1));
        end
    endtask

    task automatic test_wlast_err();
        tests_run++;
        if (proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clean: proto_err=%b expected 0", proto_err);
        end
        write_burst(32'h1000, 8'd3, 3'd5, 2'b01, 1);
        tests_run++;
        if (wr_beats != 4 || post_wready !== 1'b0 || proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL early_wlast: beats=%0d wready=%b proto_err=%b expected 4 0 1",
                     wr_beats, post_wready, proto_err);
        end
        @(posedge clk); #1;
        tests_run++;
        if (s_axi_awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_awready: awready=%b expected 1", s_axi_awready);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = IW'(128 + k);
            #1;
            tests_run++;
            if (dbg_rdata !== beat_word(k)) begin
                tests_failed++;
                $display("FAIL err_word%0d: got %h expected %h", k, dbg_rdata, beat_word(k));
            end
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: proto_err=%b expected 1", proto_err);
        end
    endtask

    task automatic test_reset_midburst();
        int n;
        @(posedge clk); #1;
        s_axi_araddr = 32'h0; s_axi_arlen = 8'd7; s_axi_arsize = 3'd5; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== t3_word(3)) begin
            tests_failed++;
            $display("FAIL mid_beat3: rvalid=%b data=%h expected 1 %h", s_axi_rvalid, s_axi_rdata, t3_word(3));
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (s_axi_rvalid !== 1'b0 || proto_err !== 1'b0 || s_axi_rdata !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: rvalid=%b proto_err=%b rdata=%h expected 0 0 0",
                     s_axi_rvalid, proto_err, s_axi_rdata);
        end
        s_axi_rready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (s_axi_arready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_release: arready=%b expected 0", s_axi_arready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_ready: arready=%b rvalid=%b expected 1 0", s_axi_arready, s_axi_rvalid);
        end
        read_burst(32'h0, 8'd7, 3'd5, 2'b01, 1'b0);
        tests_run++;
        if (rd_data.size() != 8) begin
            tests_failed++;
            $display("FAIL mid_again_count: beats=%0d expected 8", rd_data.size());
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            tests_run++;
            if (rd_data[i] !== t3_word(i) || rd_last[i] !== (i == 7)) begin
                tests_failed++;
                $display("FAIL mid_again_beat%0d: data=%h last=%b expected %h %b", i, rd_data[i],
                         rd_last[i], t3_word(i), (i == 7));
            end
        end
    endtask

    task automatic test_oversize();
        read_burst(32'h0, 8'd1, 3'd7, 2'b01, 1'b0);
        tests_run++;
        if (proto_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL oversize_err: proto_err=%b expected 1", proto_err);
        end
        tests_run++;
        if (rd_data.size() != 2 || rd_data[0] !== t3_word(0) || rd_data[1] !== t3_word(1)) begin
            tests_failed++;
            $display("FAIL oversize_clamp: beats=%0d d1=%h expected 2 %h", rd_data.size(),
                     (rd_data.size() > 1) ? rd_data[1] : '0, t3_word(1));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_preload();
        test_read_incr();
        test_read_stall();
        test_write_narrow();
        test_read_fixed_wrap();
        test_write_readback();
        test_wlast_err();
        test_reset_midburst();
        test_oversize();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_tensor_mem_slave.md
Name: axi_tensor_mem_slave

Overview:
AXI responder memory that sits on the far side of the tensor core's AXI read/write master ports. It serves AR/R read bursts (operand fetch) and AW/W write bursts (result writeback) from a single internal word-organised RAM. It is used as the system-level memory model and as the bench target for tensorcore_top. The write response channel is not implemented, because the initiator has no B channel.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 256, RAM word and R/W data width in bits; must be a power of two, at least 32.
DEPTH, 4096, number of DATA_WIDTH-bit RAM words; must be a power of two.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
s_axi_araddr  input  ADDR_WIDTH  read burst start byte address
s_axi_arlen  input  8  read beats minus 1
s_axi_arsize  input  3  log2 bytes per read beat
s_axi_arburst  input  2  read burst type
s_axi_arvalid  input  1  read address valid
s_axi_arready  output  1  read address ready
s_axi_rdata  output  DATA_WIDTH  read data
s_axi_rlast  output  1  final read beat
s_axi_rvalid  output  1  read data valid
s_axi_rready  input  1  read data ready
s_axi_awaddr  input  ADDR_WIDTH  write burst start byte address
s_axi_awlen  input  8  write beats minus 1
s_axi_awsize  input  3  log2 bytes per write beat
s_axi_awburst  input  2  write burst type
s_axi_awvalid  input  1  write address valid
s_axi_awready  output  1  write address ready
s_axi_wdata  input  DATA_WIDTH  write data
s_axi_wvalid  input  1  write data valid
s_axi_wready  output  1  write data ready
s_axi_wlast  input  1  final write beat from master
proto_err  output  1  sticky flag: wlast mismatch or size exceeding DATA_WIDTH
dbg_addr  input  log2(DEPTH)  backdoor word index
dbg_we  input  1  backdoor write strobe; has priority over an AXI write to the same word in the same cycle
dbg_wdata  input  DATA_WIDTH  backdoor write data
dbg_rdata  output  DATA_WIDTH  combinational RAM[dbg_addr]

Behaviour:
- Reset (async): all FSMs go IDLE; arready, awready, rvalid, rlast, wready and proto_err are 0; rdata is 0. RAM contents are not reset. Any burst in flight is abandoned with no further beats.
- Ready after reset: arready and awready are registered and rise on the first clk edge after rst deasserts.
- Address mapping: word index = (addr >> log2(DATA_WIDTH/8)) mod DEPTH, so addresses wrap around the RAM.
- Beat address step: 2^size bytes per beat for INCR (2'b01) and for the reserved codes 2'b10/2'b11; no step for FIXED (2'b00).
- Oversized beats: a size greater than log2(DATA_WIDTH/8) sets proto_err and is clamped to that maximum.

Read FSM, states R_IDLE and R_DATA:
- R_IDLE: arready=1. On arvalid&&arready at edge N, latch address, len, size and burst; go to R_DATA; arready=0.
- Beat 0: rvalid=1 from cycle N+1 with rdata = RAM[word(addr)].
- Each rvalid&&rready handshake advances the beat; the next beat's data appears the following cycle. Sustained throughput is 1 beat/cycle while rready=1.
- rlast=1 only on beat arlen.
- rvalid, rdata and rlast hold stable while rready=0.
- After the last handshake: rvalid=0 and back to R_IDLE, with arready=1 in the following cycle.
- Narrow reads return the full RAM word; the master selects the bytes it needs.

Write FSM, states W_IDLE, W_DATA and W_DRAIN:
- W_IDLE: awready=1, wready=0. On the AW handshake, latch address, len, size and burst; go to W_DATA with wready=1 the next cycle.
- Each wvalid&&wready writes at that edge. Full-size beats write the whole word. Narrow beats (size < max) write wdata[8*2^size-1:0] into the byte lane at (addr mod DATA_WIDTH/8); other bytes are unchanged.
- The slave counts beats itself and ends the burst after awlen+1 beats regardless of wlast.
- wlast=1 on an earlier beat: set proto_err and keep accepting beats up to the count.
- wlast=0 on the final beat: set proto_err.
- After the final beat: wready=0 and the FSM goes to W_DRAIN for one cycle, then W_IDLE (awready=1).

Concurrency and collisions:
- The read and write FSMs run independently and concurrently.
- Write-then-read: a write committed at edge E is visible to any read data fetched at or after edge E+1.
- Read beat and write to the same word at the same edge: the read returns the old data.

Test Plan:
1. dbg-preload words 0..7 with value i*0x1111; AR at addr 0x0, arlen=7, arsize=5, INCR, rready=1 -> 8 consecutive rvalid beats returning words 0..7; rlast only on beat 7; arready back to 1 one cycle after the last beat.
2. Repeat test 1 with rready toggling 1-0-0-1 -> rdata and rlast held stable during stalls; the complete sequence arrives unchanged.
3. AW at addr 0x0, awlen=255, awsize=2, wdata[31:0]=beat index, wlast on beat 255 -> RAM word k bytes [4j+3:4j] = 8k+j for all 256 beats; proto_err=0.
4. FIXED read at addr 0x20, arlen=3 -> 4 beats all equal to word 1. Read at addr (DEPTH*32)+0x40 -> returns word 2 (wrap).
5. Write with awlen=3 and wlast asserted on beat 1 -> 4 beats accepted; proto_err=1 and stays 1 until rst.
6. Assert rst during beat 3 of an 8-beat read -> rvalid=0 immediately; arready=1 one edge after release; a new burst completes correctly.
